// File: rtl/dac_spi_tx.sv
// Sample FIFO feeding a 16-bit SPI DAC word transmitter ({CFG_BITS, sample}, mode 0, MSB first).
// Optional explicit LDAC latch pulse after each frame: define DAC_LDAC_SYNC_EN.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV  = 2,
  parameter logic [3:0]  CFG_BITS = 4'b0011
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  input  logic        vsync_in,
  output logic        sample_ready,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi,
  output logic        dac_ldac_n,
  output logic        frame_sync,
  output logic        overflow
);

  localparam int unsigned DW    = 12;
  localparam int unsigned EW    = DW + 1;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned TW    = 9;
  localparam int unsigned HW    = 5;
  localparam int unsigned SW    = 16;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, DESEL, LDAC} state_e;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          sample_ready_q, overflow_q;
  logic          push_c, pop_c, full_c, empty_c;
  logic [EW-1:0] head_c;

  state_e        state_q;
  logic [TW-1:0] div_q;
  logic [HW-1:0] half_q;
  logic [SW-1:0] shreg_q;
  logic          cs_n_q, sclk_q, mosi_q, ldac_n_q, frame_sync_q;

  // FIFO control: writes are gated by the pre-pop full state
  always_comb begin
    full_c  = (count_q == CW'(DEPTH));
    empty_c = (count_q == '0);
    push_c  = sample_valid && !full_c;
    pop_c   = (state_q == IDLE) && !empty_c;
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    head_c  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clkin) begin
    if (push_c) mem_q[wr_ptr_q] <= {vsync_in, sample_in};
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      sample_ready_q <= 1'b1;
      overflow_q     <= 1'b0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q        <= count_d;
      sample_ready_q <= (count_d != CW'(DEPTH));
      if (sample_valid && full_c) overflow_q <= 1'b1;
    end
  end

  // Frame sequencer; the pop edge is the cs_n falling edge, LOAD is the first SCLK-low cycle
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      div_q        <= '0;
      half_q       <= '0;
      shreg_q      <= '0;
      cs_n_q       <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      ldac_n_q     <= 1'b1;
      frame_sync_q <= 1'b0;
    end else begin
      frame_sync_q <= 1'b0;
`ifndef DAC_LDAC_SYNC_EN
      ldac_n_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (!empty_c) begin
            state_q      <= LOAD;
            shreg_q      <= {CFG_BITS, head_c[DW-1:0]};
            mosi_q       <= CFG_BITS[3];
            cs_n_q       <= 1'b0;
            frame_sync_q <= head_c[DW];
            div_q        <= '0;
            half_q       <= '0;
          end
        end
        LOAD, SHIFT: begin
          state_q <= SHIFT;
          if (div_q == TW'(CLK_DIV - 1)) begin
            div_q <= '0;
            if (half_q == HW'(31)) begin
              state_q <= DESEL;
              cs_n_q  <= 1'b1;
              sclk_q  <= 1'b0;
              mosi_q  <= 1'b0;
            end else begin
              half_q <= half_q + HW'(1);
              sclk_q <= ~sclk_q;
              if (sclk_q) begin
                shreg_q <= {shreg_q[SW-2:0], 1'b0};
                mosi_q  <= shreg_q[SW-2];
              end
            end
          end else begin
            div_q <= div_q + TW'(1);
          end
        end
        DESEL: begin
          if (div_q == TW'(2 * CLK_DIV - 1)) begin
            div_q <= '0;
`ifdef DAC_LDAC_SYNC_EN
            state_q  <= LDAC;
            ldac_n_q <= 1'b0;
`else
            state_q  <= IDLE;
`endif
          end else begin
            div_q <= div_q + TW'(1);
          end
        end
        LDAC: begin
          if (div_q == TW'(CLK_DIV - 1)) begin
            div_q    <= '0;
            ldac_n_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            div_q <= div_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_ready = sample_ready_q;
  assign overflow     = overflow_q;
  assign dac_cs_n     = cs_n_q;
  assign dac_sclk     = sclk_q;
  assign dac_mosi     = mosi_q;
  assign dac_ldac_n   = ldac_n_q;
  assign frame_sync   = frame_sync_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: two instances (CLK_DIV=2 and CLK_DIV=1), an SPI line decoder and an
// expected-word queue built from the accepted samples.
module tb_dac_spi_tx;

  localparam int unsigned D0  = 2;
  localparam int unsigned D1  = 1;
  localparam logic [3:0]  CFG = 4'b0011;
  localparam int          MAXF = 64;

  logic        clkin = 1'b0;
  logic        rst_n;
  logic [1:0]  sv, vs;
  logic [11:0] sd [2];
  logic [1:0]  rdy, cs, sclk, mosi, ldac, fsync, ovf;

  always #5 clkin = ~clkin;

  dac_spi_tx #(.CLK_DIV(D0)) dut0 (
    .clkin(clkin), .rst_n(rst_n), .sample_in(sd[0]), .sample_valid(sv[0]), .vsync_in(vs[0]),
    .sample_ready(rdy[0]), .dac_cs_n(cs[0]), .dac_sclk(sclk[0]), .dac_mosi(mosi[0]),
    .dac_ldac_n(ldac[0]), .frame_sync(fsync[0]), .overflow(ovf[0]));

  dac_spi_tx #(.CLK_DIV(D1)) dut1 (
    .clkin(clkin), .rst_n(rst_n), .sample_in(sd[1]), .sample_valid(sv[1]), .vsync_in(vs[1]),
    .sample_ready(rdy[1]), .dac_cs_n(cs[1]), .dac_sclk(sclk[1]), .dac_mosi(mosi[1]),
    .dac_ldac_n(ldac[1]), .frame_sync(fsync[1]), .overflow(ovf[1]));

  int n_assert = 0;
  int n_fail   = 0;

  int          n_got [2], n_exp [2], vidx [2], bad [2], rises [2], gap_min [2];
  int          high_cnt [2], len [2], bits [2], ldac_len [2], ldac_pulses [2];
  logic [15:0] got_word [2][MAXF];
  logic [15:0] exp_word [2][MAXF];
  int          got_len  [2][MAXF];
  int          got_bits [2][MAXF];
  logic        got_fs   [2][MAXF];
  logic        exp_fs   [2][MAXF];
  logic [15:0] cur_word [2];
  logic        cur_fs [2], in_fr [2], seen_rise [2], p_cs [2], p_sclk [2], p_ldac [2];

  // SPI line decoder: one record per completed cs_n-low window, plus protocol sanity counters
  always @(posedge clkin) begin : mon
`ifdef DAC_LDAC_SYNC_EN
    int d;
`endif
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        in_fr[i] = 1'b0; p_cs[i] = 1'b1; p_sclk[i] = 1'b0; p_ldac[i] = 1'b1;
        seen_rise[i] = 1'b0; high_cnt[i] = 0; ldac_len[i] = 0;
      end else begin
        if (!p_sclk[i] && sclk[i]) rises[i]++;
        if (p_cs[i] && !cs[i]) begin
          if (seen_rise[i] && high_cnt[i] < gap_min[i]) gap_min[i] = high_cnt[i];
          in_fr[i] = 1'b1; len[i] = 1; bits[i] = 0; cur_word[i] = '0; cur_fs[i] = fsync[i];
        end else if (!cs[i] && in_fr[i]) begin
          len[i]++;
          if (!p_sclk[i] && sclk[i]) begin
            cur_word[i] = {cur_word[i][14:0], mosi[i]};
            bits[i]++;
          end
        end else if (!p_cs[i] && cs[i] && in_fr[i]) begin
          if (n_got[i] < MAXF) begin
            got_word[i][n_got[i]] = cur_word[i];
            got_len[i][n_got[i]]  = len[i];
            got_bits[i][n_got[i]] = bits[i];
            got_fs[i][n_got[i]]   = cur_fs[i];
          end
          n_got[i]++;
          in_fr[i] = 1'b0; high_cnt[i] = 1; seen_rise[i] = 1'b1;
        end else if (cs[i]) begin
          high_cnt[i]++;
        end
        if (cs[i] && (mosi[i] || sclk[i])) bad[i]++;
        if (fsync[i] && !(p_cs[i] && !cs[i])) bad[i]++;
`ifdef DAC_LDAC_SYNC_EN
        d = (i == 0) ? int'(D0) : int'(D1);
        if (!ldac[i]) begin
          if (p_ldac[i]) begin
            ldac_pulses[i]++;
            if (!(cs[i] && high_cnt[i] == 2 * d + 1)) bad[i]++;
          end
          ldac_len[i]++;
        end else if (!p_ldac[i]) begin
          if (ldac_len[i] != d) bad[i]++;
          ldac_len[i] = 0;
        end
`else
        if (ldac[i]) bad[i]++;
`endif
        p_cs[i] = cs[i]; p_sclk[i] = sclk[i]; p_ldac[i] = ldac[i];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [11:0] d, input logic tag);
    exp_word[i][n_exp[i]] = {CFG, d};
    exp_fs[i][n_exp[i]]   = tag;
    n_exp[i]++;
  endtask

  task automatic wait_done(input int i);
    int k;
    k = 0;
    while (n_got[i] < n_exp[i] && k < 3000) begin
      @(negedge clkin);
      k++;
    end
    repeat (20) @(negedge clkin);
    chk($sformatf("frames_done_%0d", i), n_got[i], n_exp[i]);
  endtask

  task automatic verify(input int i);
    int d;
    d = (i == 0) ? int'(D0) : int'(D1);
    for (int j = vidx[i]; j < n_exp[i] && j < MAXF; j++) begin
      chk($sformatf("word_%0d_%0d", i, j), 32'(got_word[i][j]), 32'(exp_word[i][j]));
      chk($sformatf("cs_len_%0d_%0d", i, j), got_len[i][j], 32 * d);
      chk($sformatf("bits_%0d_%0d", i, j), got_bits[i][j], 16);
      chk($sformatf("fsync_%0d_%0d", i, j), 32'(got_fs[i][j]), 32'(exp_fs[i][j]));
    end
    vidx[i] = n_exp[i];
  endtask

  initial begin
    int n, edges, k, base_r, base_g;
    logic prev;
    logic [11:0] r;
    for (int i = 0; i < 2; i++) begin
      n_got[i] = 0; n_exp[i] = 0; vidx[i] = 0; bad[i] = 0; rises[i] = 0;
      gap_min[i] = 1000000; ldac_pulses[i] = 0; high_cnt[i] = 0; ldac_len[i] = 0;
      in_fr[i] = 1'b0; seen_rise[i] = 1'b0; p_cs[i] = 1'b1; p_sclk[i] = 1'b0; p_ldac[i] = 1'b1;
    end
    rst_n = 1'b0; sv = '0; vs = '0; sd[0] = '0; sd[1] = '0;
    repeat (3) @(negedge clkin);
    chk("rst_cs_n", 32'(cs), 32'h3);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(mosi), 32'h0);
    chk("rst_ldac_n", 32'(ldac), 32'h3);
    chk("rst_frame_sync", 32'(fsync), 32'h0);
    chk("rst_overflow", 32'(ovf), 32'h0);
    chk("rst_ready", 32'(rdy), 32'h3);
    rst_n = 1'b1;

    // single 0xABC frame, cs_n falls on the 2nd edge after acceptance
    @(negedge clkin);
    sv[0] = 1'b1; sd[0] = 12'hABC; vs[0] = 1'b0;
    push_exp(0, 12'hABC, 1'b0);
    @(posedge clkin); #1;
    chk("cs_after_edge1", 32'(cs[0]), 32'h1);
    @(negedge clkin);
    sv[0] = 1'b0;
    @(posedge clkin); #1;
    chk("cs_after_edge2", 32'(cs[0]), 32'h0);
    wait_done(0);
    verify(0);

    // six back-to-back strobes: five accepted, sixth dropped; vsync on the third only
    for (int j = 0; j < 6; j++) begin
      @(negedge clkin);
      if (j == 5) begin
        chk("ready_full", 32'(rdy[0]), 32'h0);
        chk("ovf_before_drop", 32'(ovf[0]), 32'h0);
      end
      r = 12'($urandom);
      sv[0] = 1'b1; sd[0] = r; vs[0] = (j == 2 || j == 5);
      if (j < 5) push_exp(0, r, (j == 2));
    end
    @(negedge clkin);
    sv[0] = 1'b0; vs[0] = 1'b0;
    chk("ovf_after_drop", 32'(ovf[0]), 32'h1);
    wait_done(0);
    verify(0);
    chk("ovf_sticky", 32'(ovf[0]), 32'h1);
    chk("ready_drained", 32'(rdy[0]), 32'h1);

    // CLK_DIV=1 extremes
    @(negedge clkin);
    sv[1] = 1'b1; sd[1] = 12'h000; vs[1] = 1'b0; push_exp(1, 12'h000, 1'b0);
    @(negedge clkin);
    sd[1] = 12'hFFF; push_exp(1, 12'hFFF, 1'b0);
    @(negedge clkin);
    sv[1] = 1'b0;
    wait_done(1);
    verify(1);

    // random bursts of 1..4 samples into both instances
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        @(negedge clkin);
        sv = 2'b11;
        for (int i = 0; i < 2; i++) begin
          sd[i] = 12'($urandom);
          vs[i] = 1'($urandom);
          push_exp(i, sd[i], vs[i]);
        end
      end
      @(negedge clkin);
      sv = '0; vs = '0;
      wait_done(0);
      wait_done(1);
      verify(0);
      verify(1);
    end

    // reset at the 7th SCLK edge of a frame
    @(negedge clkin);
    sv[0] = 1'b1; sd[0] = 12'h5A5;
    @(negedge clkin);
    sv[0] = 1'b0;
    edges = 0; k = 0; prev = sclk[0];
    while (edges < 7 && k < 1000) begin
      @(posedge clkin); #1;
      if (sclk[0] != prev) edges++;
      prev = sclk[0];
      k++;
    end
    chk("abort_edge7_reached", edges, 7);
    rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs[0]), 32'h1);
    chk("abort_sclk", 32'(sclk[0]), 32'h0);
    chk("abort_mosi", 32'(mosi[0]), 32'h0);
    chk("abort_ldac_n", 32'(ldac[0]), 32'h1);
    chk("abort_overflow", 32'(ovf[0]), 32'h0);
    chk("abort_ready", 32'(rdy[0]), 32'h1);
    repeat (2) @(negedge clkin);
    rst_n = 1'b1;
    base_r = rises[0]; base_g = n_got[0];
    repeat (150) @(negedge clkin);
    chk("no_sclk_after_abort", rises[0], base_r);
    chk("no_frame_after_abort", n_got[0], base_g);
    chk("cs_idle_after_abort", 32'(cs[0]), 32'h1);
    @(negedge clkin);
    sv[0] = 1'b1; sd[0] = 12'h123; vs[0] = 1'b1; push_exp(0, 12'h123, 1'b1);
    @(negedge clkin);
    sv[0] = 1'b0; vs[0] = 1'b0;
    wait_done(0);
    verify(0);

    chk("protocol_0", bad[0], 0);
    chk("protocol_1", bad[1], 0);
    chk("desel_gap_0", 32'(gap_min[0] >= int'(2 * D0)), 32'h1);
    chk("desel_gap_1", 32'(gap_min[1] >= int'(2 * D1)), 32'h1);
`ifdef DAC_LDAC_SYNC_EN
    chk("ldac_pulses_0", ldac_pulses[0], n_got[0]);
    chk("ldac_pulses_1", ldac_pulses[1], n_got[1]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
